// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: execute/memory pipe payloads, data-bus request/response, FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package memory_stage_pkg;

  localparam int XLEN = 64;

  // Access size encoding carried on the data bus (bytes = 1 << size).
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic   memRead;
    logic   memWrite;
    msize_t msize;
    logic   memUnsigned;
  } control_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] srcb;
    logic [4:0]      dst;
    control_t        ctl;
  } execute_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      dst;
    logic [XLEN-1:0] result;
    control_t        ctl;
    logic            exc_misalign;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mstate_t;

  // Byte-enable pattern for an access of the given size starting at lane 0.
  function automatic logic [7:0] size_mask(msize_t s);
    case (s)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  // Address low bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(msize_t s);
    case (s)
      MSIZE1:  return 3'b000;
      MSIZE2:  return 3'b001;
      MSIZE4:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Lane steering for the 8-byte data bus: store data/strobe placement and load extract + extend.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; follows its inputs.
// Ports: offset (byte lane), size, is_unsigned, store_src -> strobe/store_data;
//        load_raw (full bus dword) -> load_data (extended to 64 bits).
module mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]  offset,
  input  msize_t      size,
  input  logic        is_unsigned,
  input  logic [63:0] store_src,
  input  logic [63:0] load_raw,
  output logic [7:0]  strobe,
  output logic [63:0] store_data,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] lane;

  assign shamt      = {offset, 3'b000};
  assign strobe     = size_mask(size) << offset;
  // Operand is placed in its byte lane; bytes outside the strobe are don't-care.
  assign store_data = store_src << shamt;
  assign lane       = load_raw >> shamt;

  always_comb begin
    load_data = lane;
    case (size)
      MSIZE1:  load_data = is_unsigned ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      MSIZE2:  load_data = is_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      MSIZE4:  load_data = is_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: one data-bus access per load/store, load extend, store strobes; ALU ops pass through.
// Latency: non-memory ops 0 cycles; memory ops issue cycle n, result at n+1+bus waits.
// Backpressure: stallM holds IF..EX (dataE stable) from issue until the bus returns data_ok.
// Ports: clk, reset (sync, active-high), dataE (from execute), dreq/dresp (data bus),
//        stallM (front-end hold), dataM (to writeback).
// Build option: MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          stallM,
  output memory_data_t  dataM
);

  mstate_t     state, state_n;
  logic [63:0] rdata_q;
  logic        memop;
  logic        is_load;
  logic        is_store;
  logic        trap;
  logic        capture;
  logic [63:0] addr;
  logic [7:0]  lane_strobe;
  logic [63:0] lane_wdata;
  logic [63:0] load_data;
  logic        unused_ok;

  assign memop    = dataE.valid & (dataE.ctl.memRead | dataE.ctl.memWrite);
  // Both flags set is treated as a load.
  assign is_load  = dataE.ctl.memRead;
  assign is_store = dataE.ctl.memWrite & ~dataE.ctl.memRead;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(dataE.alu_out[2:0] & align_mask(dataE.ctl.msize));
  assign addr       = dataE.alu_out;
  assign trap       = memop & misaligned;
`else
  // Low address bits below the access size are dropped so the bus always sees aligned requests.
  assign addr = {dataE.alu_out[63:3], dataE.alu_out[2:0] & ~align_mask(dataE.ctl.msize)};
  assign trap = 1'b0;
`endif

  // The bus handshake only needs data_ok; addr_ok is informational here.
  assign unused_ok = dresp.addr_ok;

  mem_align u_align (
    .offset     (addr[2:0]),
    .size       (dataE.ctl.msize),
    .is_unsigned(dataE.ctl.memUnsigned),
    .store_src  (dataE.srcb),
    .load_raw   (rdata_q),
    .strobe     (lane_strobe),
    .store_data (lane_wdata),
    .load_data  (load_data)
  );

  // data_ok may arrive in the issue cycle itself, so capture from IDLE as well as BUSY.
  assign capture = dresp.data_ok & (((state == IDLE) & memop & ~trap) | (state == BUSY));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        rdata_q <= dresp.data;
      end
    end
  end

  always_comb begin
    state_n = state;

    // Request fields come straight from dataE, which the stall keeps stable while BUSY.
    dreq.valid  = 1'b0;
    dreq.addr   = addr;
    dreq.size   = dataE.ctl.msize;
    dreq.strobe = is_store ? lane_strobe : 8'h00;
    dreq.data   = is_store ? lane_wdata  : 64'h0;

    stallM = 1'b0;

    dataM.valid        = 1'b0;
    dataM.pc           = dataE.pc;
    dataM.dst          = dataE.dst;
    dataM.result       = '0;
    dataM.ctl          = dataE.ctl;
    dataM.exc_misalign = 1'b0;

    case (state)
      IDLE: begin
        if (trap) begin
          dataM.valid        = 1'b1;
          dataM.result       = dataE.alu_out;
          dataM.exc_misalign = 1'b1;
        end else if (memop) begin
          dreq.valid = 1'b1;
          stallM     = 1'b1;
          state_n    = dresp.data_ok ? DONE : BUSY;
        end else begin
          dataM.valid  = dataE.valid;
          dataM.result = dataE.alu_out;
        end
      end
      BUSY: begin
        dreq.valid = 1'b1;
        stallM     = 1'b1;
        if (dresp.data_ok) begin
          state_n = DONE;
        end
      end
      DONE: begin
        // Stall drops here so dataE advances on this edge as dataM retires.
        dataM.valid  = 1'b1;
        dataM.result = is_load ? load_data : 64'h0;
        state_n      = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
